// File: rtl/switch_debounce4.sv
// switch_debounce4: four-channel switch input stage.
// Each raw switch is brought into the clk domain with a 2-FF synchroniser.
// It is then debounced by a small STABLE/PEND state machine with its own counter.
// The debounced values are driven out as registered A, B, C, D.
// The lanes are fully independent of each other.
//
// Optional feature, selected by the macro DBNC_CHG_STROBE_EN:
//   when the macro is defined, a one-cycle 'chg' strobe accompanies any output update.
//   when it is not defined, the chg port and its logic do not exist.

module switch_debounce4 #(
    parameter int CNT_W      = 16,
    parameter int STABLE_CNT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_raw,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D
`ifdef DBNC_CHG_STROBE_EN
    ,
    output logic       chg
`endif
);

    localparam int NUM_LANES = 4;

    // Value of the counter on the last mismatching cycle before the output is allowed to follow.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_PEND   = 1'b1
    } state_e;

    // Reject configurations whose counter could not reach STABLE_CNT-1 without wrapping.
    if ((STABLE_CNT < 1) || (STABLE_CNT >= (2 ** CNT_W))) begin : g_bad_cfg
        $error("switch_debounce4: STABLE_CNT=%0d outside 1..2**CNT_W-1 (CNT_W=%0d)",
               STABLE_CNT, CNT_W);
    end

    logic [NUM_LANES-1:0] out_vec;
`ifdef DBNC_CHG_STROBE_EN
    logic [NUM_LANES-1:0] upd_vec;
`endif

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic             s1_q;
        logic             s2_q;
        state_e           state_q;
        state_e           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             out_q;
        logic             out_d;

        // Two-flop synchroniser; only s2_q is seen by the debounce logic.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= sw_raw[i];
                s2_q <= s1_q;
            end
        end

        // Debounce next-state: the output follows s2 only after STABLE_CNT mismatching cycles in a row.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            out_d   = out_q;
            case (state_q)
                ST_STABLE: begin
                    cnt_d = '0;
                    if (s2_q != out_q) begin
                        if (STABLE_CNT == 1) begin
                            // A single cycle of mismatch is already enough.
                            out_d = s2_q;
                        end else begin
                            state_d = ST_PEND;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_PEND: begin
                    if (s2_q == out_q) begin
                        // The input went back before the stability count was reached; drop the glitch.
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        out_d   = s2_q;
                        cnt_d   = '0;
                        state_d = ST_STABLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Debounce state registers; reset wins over any partial count.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_STABLE;
                cnt_q   <= '0;
                out_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
            end
        end

        assign out_vec[i] = out_q;
`ifdef DBNC_CHG_STROBE_EN
        assign upd_vec[i] = out_d ^ out_q;
`endif
    end

    assign A = out_vec[3];
    assign B = out_vec[2];
    assign C = out_vec[1];
    assign D = out_vec[0];

`ifdef DBNC_CHG_STROBE_EN
    logic chg_q;
    logic chg_d;

    // One strobe per edge on which any lane updates, however many lanes update together.
    always_comb begin
        chg_d = |upd_vec;
    end

    // The strobe register is loaded on the same edge as the outputs, so it is high for the first cycle of the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            chg_q <= 1'b0;
        end else begin
            chg_q <= chg_d;
        end
    end

    assign chg = chg_q;
`endif

endmodule

// File: tb/tb_switch_debounce4.sv
// Bench for switch_debounce4 (STABLE_CNT=4, CNT_W=4).
// The reference model keeps a sliding window of synchronised samples per bit.
// An output follows its input once the last STABLE_CNT samples all agree and differ from the current output.
// chg is checked only when the build defines DBNC_CHG_STROBE_EN.

module tb_switch_debounce4;

    localparam int CNT_W      = 4;
    localparam int STABLE_CNT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw_raw = 4'b0000;
    logic       A, B, C, D;
`ifdef DBNC_CHG_STROBE_EN
    logic       chg;
`endif

    int compared   = 0;
    int mismatched = 0;

    switch_debounce4 #(.CNT_W(CNT_W), .STABLE_CNT(STABLE_CNT)) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_raw (sw_raw),
        .A      (A),
        .B      (B),
        .C      (C),
        .D      (D)
`ifdef DBNC_CHG_STROBE_EN
        ,
        .chg    (chg)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [3:0] m_s1  = '0;
    logic [3:0] m_s2  = '0;
    logic [3:0] m_out = '0;
    logic       m_chg = 1'b0;
    logic [3:0] win[$];

    // Advance the model by one rising edge, using the inputs that were present at that edge.
    task automatic model_edge();
        bit all_eq;
        if (rst) begin
            m_s1  = '0;
            m_s2  = '0;
            m_out = '0;
            m_chg = 1'b0;
            win.delete();
        end else begin
            win.push_back(m_s2);
            if (win.size() > STABLE_CNT) void'(win.pop_front());
            m_chg = 1'b0;
            if (win.size() == STABLE_CNT) begin
                for (int b = 0; b < 4; b++) begin
                    all_eq = 1'b1;
                    foreach (win[e]) if (win[e][b] != win[0][b]) all_eq = 1'b0;
                    if (all_eq && (win[0][b] != m_out[b])) begin
                        m_out[b] = win[0][b];
                        m_chg    = 1'b1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = sw_raw;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock edge: update the model, then compare once the outputs have settled.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ":abcd"}, {A, B, C, D}, m_out);
`ifdef DBNC_CHG_STROBE_EN
        check({tag, ":chg"}, {3'b000, chg}, {3'b000, m_chg});
`endif
    endtask

    task automatic check_chg(input string tag, input logic exp);
`ifdef DBNC_CHG_STROBE_EN
        check(tag, {3'b000, chg}, {3'b000, exp});
`else
        if (exp === 1'bx) check(tag, 4'b0000, 4'b0001);
`endif
    endtask

    initial begin
        int hold;

        // 1: reset with all switches high.
        rst    = 1'b1;
        sw_raw = 4'b1111;
        repeat (2) begin
            tick("t1_rst");
            check("t1_out0", {A, B, C, D}, 4'b0000);
            check_chg("t1_chg0", 1'b0);
        end

        // 2: A alone rises; latency is STABLE_CNT+1 edges after the first sample edge.
        rst    = 1'b0;
        sw_raw = 4'b1000;
        tick("t2_k");
        for (int j = 1; j <= 4; j++) begin
            tick("t2_wait");
            check("t2_a_low", {A, B, C, D}, 4'b0000);
        end
        tick("t2_k5");
        check("t2_a_high", {A, B, C, D}, 4'b1000);
        check_chg("t2_chg_pulse", 1'b1);
        tick("t2_k6");
        check_chg("t2_chg_end", 1'b0);

        // 3: three-cycle pulse on B never propagates.
        sw_raw = 4'b1100;
        repeat (3) begin
            tick("t3_pulse");
            check("t3_b_low", {A, B, C, D}, 4'b1000);
            check_chg("t3_no_chg", 1'b0);
        end
        sw_raw = 4'b1000;
        repeat (8) begin
            tick("t3_after");
            check("t3_b_low2", {A, B, C, D}, 4'b1000);
            check_chg("t3_no_chg2", 1'b0);
        end

        // 4: settle low, then all four rise on the same edge with a single strobe.
        sw_raw = 4'b0000;
        repeat (8) tick("t4_settle");
        sw_raw = 4'b1111;
        tick("t4_k");
        repeat (4) begin
            tick("t4_wait");
            check("t4_all_low", {A, B, C, D}, 4'b0000);
        end
        tick("t4_k5");
        check("t4_all_high", {A, B, C, D}, 4'b1111);
        check_chg("t4_chg_pulse", 1'b1);
        tick("t4_k6");
        check_chg("t4_chg_end", 1'b0);

        // 5: reset in the middle of a pending count on D.
        sw_raw = 4'b0000;
        repeat (8) tick("t5_settle");
        sw_raw = 4'b0001;
        tick("t5_k");
        tick("t5_k1");
        rst = 1'b1;
        repeat (2) begin
            tick("t5_rst");
            check("t5_d_rst", {A, B, C, D}, 4'b0000);
        end
        rst = 1'b0;
        tick("t5_m");
        repeat (4) begin
            tick("t5_wait");
            check("t5_d_low", {A, B, C, D}, 4'b0000);
        end
        tick("t5_m5");
        check("t5_d_high", {A, B, C, D}, 4'b0001);

        // Randomised bursts: independent bit flips with hold times both shorter and longer than STABLE_CNT.
        for (int n = 0; n < 150; n++) begin
            sw_raw = sw_raw ^ 4'($urandom);
            hold   = $urandom_range(1, 8);
            if ($urandom_range(0, 24) == 0) rst = 1'b1;
            for (int h = 0; h < hold; h++) begin
                tick("rnd");
                rst = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
